seq_divider: RTL

- Sequential signed restoring divider. It is the inverse-operation companion to the team's Booth shift-add multiplier.
- It uses the same narrow serial operand-load protocol: one shared `data_in` bus, a `start` strobe, and a `done` pulse.
- It computes quotient and remainder in one iteration per clock, using an A/Q/M register datapath driven by a separate controller FSM.
- It sits beside the multiplier in the arithmetic test datapath.

---
 rtl/div_pkg.sv | 22 ++
 rtl/seq_divider_if.sv | 23 ++
 rtl/div_controller.sv | 85 ++++++++
 rtl/div_datapath.sv | 151 +++++++++++++++
 rtl/seq_divider.sv | 56 +++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential signed restoring divider.
package div_pkg;

    localparam int unsigned DefaultWidth = 5;
    localparam int unsigned MagWidth     = 32;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StLoadD = 3'd1,
        StCalc  = 3'd2,
        StFix   = 3'd3,
        StDone  = 3'd4
    } state_e;

    // Conditional two's-complement negate; callers zero-extend a narrower value and keep the
    // low bits, which gives |x| for a negative operand (most-negative maps to 2^(W-1)).
    function automatic logic [MagWidth-1:0] twos_mag(input logic [MagWidth-1:0] value,
                                                     input logic                neg);
        return neg ? ({MagWidth{1'b0}} - value) : value;
    endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Operand-load / result bundle of the sequential divider.
interface seq_divider_if #(
    parameter int unsigned W = div_pkg::DefaultWidth
) ();
    logic         start;
    logic [W-1:0] data_in;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic         overflow;

    modport master (
        output start, data_in,
        input  quotient, remainder, busy, done, div_by_zero, overflow
    );

    modport slave (
        input  start, data_in,
        output quotient, remainder, busy, done, div_by_zero, overflow
    );
endinterface

// File: rtl/div_controller.sv
// Divider sequencing FSM: IDLE -> LOAD_D -> CALC (W steps) -> FIX -> DONE -> IDLE.
module div_controller
    import div_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic start_i,
    input  logic a_neg_i,
    input  logic count_zero_i,
    output logic load_dvd_o,
    output logic load_dvs_o,
    output logic shift_o,
    output logic restore_o,
    output logic dec_o,
    output logic fix_o,
    output logic busy_o,
    output logic done_o
);
    state_e state_q, state_d;
    logic   busy_q, busy_d;
    logic   done_q, done_d;

    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        load_dvd_o = 1'b0;
        load_dvs_o = 1'b0;
        shift_o    = 1'b0;
        restore_o  = 1'b0;
        dec_o      = 1'b0;
        fix_o      = 1'b0;

        case (state_q)
            StIdle: begin
                if (start_i) begin
                    load_dvd_o = 1'b1;
                    busy_d     = 1'b1;
                    state_d    = StLoadD;
                end
            end
            StLoadD: begin
                load_dvs_o = 1'b1;
                state_d    = StCalc;
            end
            StCalc: begin
                shift_o   = 1'b1;
                restore_o = a_neg_i;
                dec_o     = 1'b1;
                if (count_zero_i) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                fix_o   = 1'b1;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule

// File: rtl/div_datapath.sv
// A/Q/M restoring-division datapath: operand capture, one iteration per step, sign fix-up.
module div_datapath
    import div_pkg::*;
#(
    parameter int unsigned W = DefaultWidth
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] data_in_i,
    input  logic         load_dvd_i,
    input  logic         load_dvs_i,
    input  logic         shift_i,
    input  logic         restore_i,
    input  logic         dec_i,
    input  logic         fix_i,
    output logic         a_neg_o,
    output logic         count_zero_o,
    output logic [W-1:0] quotient_o,
    output logic [W-1:0] remainder_o,
    output logic         div_by_zero_o,
    output logic         overflow_o
);
    localparam int unsigned CntW = $clog2(W + 1);

    logic [W:0]      a_q, a_d;
    logic [W-1:0]    q_q, q_d;
    logic [W-1:0]    m_q, m_d;
    logic [W-1:0]    dvd_q, dvd_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            sgn_dvd_q, sgn_dvd_d;
    logic            sgn_dvs_q, sgn_dvs_d;
    logic            dz_q, dz_d;
    logic [W-1:0]    quo_q, quo_d;
    logic [W-1:0]    rem_q, rem_d;
    logic            dbz_q, dbz_d;
    logic            ovf_q, ovf_d;

    logic [W:0]          a_shift;
    logic [W:0]          a_trial;
    logic [MagWidth-1:0] in_mag;
    logic [MagWidth-1:0] q_signed;
    logic [MagWidth-1:0] r_signed;
    logic                q_neg;
    logic                unused_bits;

    assign a_shift = {a_q[W-1:0], q_q[W-1]};
    assign a_trial = a_shift - {1'b0, m_q};
    assign a_neg_o = a_trial[W];

    // High on the step that takes the iteration count to zero.
    assign count_zero_o = (cnt_q == CntW'(1));

    assign q_neg    = sgn_dvd_q ^ sgn_dvs_q;
    assign in_mag   = twos_mag(MagWidth'(data_in_i), data_in_i[W-1]);
    assign q_signed = twos_mag(MagWidth'(q_q), q_neg);
    assign r_signed = twos_mag(MagWidth'(a_q[W-1:0]), sgn_dvd_q);

    // A never goes negative after restore, so its top bit is only a borrow guard.
    assign unused_bits = ^{in_mag[MagWidth-1:W], q_signed[MagWidth-1:W],
                           r_signed[MagWidth-1:W], a_q[W]};

    always_comb begin
        a_d       = a_q;
        q_d       = q_q;
        m_d       = m_q;
        dvd_d     = dvd_q;
        cnt_d     = cnt_q;
        sgn_dvd_d = sgn_dvd_q;
        sgn_dvs_d = sgn_dvs_q;
        dz_d      = dz_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dbz_d     = dbz_q;
        ovf_d     = ovf_q;

        if (load_dvd_i) begin
            dvd_d     = data_in_i;
            sgn_dvd_d = data_in_i[W-1];
            q_d       = in_mag[W-1:0];
            a_d       = '0;
            dz_d      = 1'b0;
        end

        if (load_dvs_i) begin
            sgn_dvs_d = data_in_i[W-1];
            m_d       = in_mag[W-1:0];
            cnt_d     = CntW'(W);
            dz_d      = (data_in_i == '0);
        end

        if (shift_i) begin
            // Restoring simply discards the trial difference.
            a_d = restore_i ? a_shift : a_trial;
            q_d = {q_q[W-2:0], ~restore_i};
        end

        if (dec_i) begin
            cnt_d = cnt_q - CntW'(1);
        end

        if (fix_i) begin
            if (dz_q) begin
                quo_d = '1;
                rem_d = dvd_q;
                dbz_d = 1'b1;
                ovf_d = 1'b0;
            end else begin
                quo_d = q_signed[W-1:0];
                rem_d = r_signed[W-1:0];
                dbz_d = 1'b0;
                ovf_d = (q_q == {1'b1, {(W-1){1'b0}}}) && !q_neg;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q       <= '0;
            q_q       <= '0;
            m_q       <= '0;
            dvd_q     <= '0;
            cnt_q     <= '0;
            sgn_dvd_q <= 1'b0;
            sgn_dvs_q <= 1'b0;
            dz_q      <= 1'b0;
            quo_q     <= '0;
            rem_q     <= '0;
            dbz_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            a_q       <= a_d;
            q_q       <= q_d;
            m_q       <= m_d;
            dvd_q     <= dvd_d;
            cnt_q     <= cnt_d;
            sgn_dvd_q <= sgn_dvd_d;
            sgn_dvs_q <= sgn_dvs_d;
            dz_q      <= dz_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dbz_q     <= dbz_d;
            ovf_q     <= ovf_d;
        end
    end

    assign quotient_o    = quo_q;
    assign remainder_o   = rem_q;
    assign div_by_zero_o = dbz_q;
    assign overflow_o    = ovf_q;

endmodule

// File: rtl/seq_divider.sv
// Sequential signed restoring divider: serial operand load, one quotient bit per clock.
module seq_divider
    import div_pkg::*;
#(
    parameter int unsigned W = DefaultWidth
) (
    input logic          clk,
    input logic          rst_n,
    seq_divider_if.slave bus
);
    logic load_dvd;
    logic load_dvs;
    logic shift;
    logic restore;
    logic dec;
    logic fix;
    logic a_neg;
    logic count_zero;

    div_controller u_ctrl (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (bus.start),
        .a_neg_i      (a_neg),
        .count_zero_i (count_zero),
        .load_dvd_o   (load_dvd),
        .load_dvs_o   (load_dvs),
        .shift_o      (shift),
        .restore_o    (restore),
        .dec_o        (dec),
        .fix_o        (fix),
        .busy_o       (bus.busy),
        .done_o       (bus.done)
    );

    div_datapath #(
        .W (W)
    ) u_dp (
        .clk           (clk),
        .rst_n         (rst_n),
        .data_in_i     (bus.data_in),
        .load_dvd_i    (load_dvd),
        .load_dvs_i    (load_dvs),
        .shift_i       (shift),
        .restore_i     (restore),
        .dec_i         (dec),
        .fix_i         (fix),
        .a_neg_o       (a_neg),
        .count_zero_o  (count_zero),
        .quotient_o    (bus.quotient),
        .remainder_o   (bus.remainder),
        .div_by_zero_o (bus.div_by_zero),
        .overflow_o    (bus.overflow)
    );

endmodule
